char_word_packer: RTL and testbench

CHAR_WORD_PACKER -- requirements
Module: char_word_packer

---
 rtl/char_word_packer.sv | 204 ++++++++++++++++++++
 tb/tb_char_word_packer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_word_packer.sv
// char_word_packer: packs bytes into 32-bit words, first byte in [7:0], and queues them in a FWFT word FIFO; PACKER_NUL_TERM_EN makes 8'h00 act as a flush.
// Latency: a word completed or flushed in cycle N is presented with out_valid in cycle N+1.
// Backpressure: in_ready drops only while a push is needed and the FIFO is full, or while a flush waits for space.

module cwp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (level == DEPTH_LVL);
  assign pop_vld = (level != '0);
  assign pop_dat = pop_vld ? mem[rd_ptr] : '0;
  assign push    = push_vld && !full;
  assign pop     = pop_vld && pop_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module char_word_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_char,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_flush,
  output logic [31:0]                 out_word,
  output logic [2:0]                  out_count,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  typedef struct packed {
    logic        last;
    logic [2:0]  count;
    logic [31:0] word;
  } word_t;

  typedef enum logic {FILL = 1'b0, FLUSH_WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [31:0] lanes, lanes_nxt;
  logic [31:0] merged;
  logic [2:0]  fill_cnt;
  logic        fifo_full;
  logic        accept;
  logic        store_byte;
  logic        flush_req;
  logic        push_vld;
  word_t       push_dat;
  word_t       pop_dat;

  assign in_ready = !rst && (state == FILL) && (idx != 2'd3 || !fifo_full);
  assign accept   = in_valid && in_ready;

`ifdef PACKER_NUL_TERM_EN
  assign store_byte = accept && (in_char != 8'h00);
  assign flush_req  = in_flush || (accept && (in_char == 8'h00));
`else
  assign store_byte = accept;
  assign flush_req  = in_flush;
`endif

  // Assembler view with this cycle's byte already placed in its lane.
  always_comb begin
    merged = lanes;
    if (store_byte) merged[{idx, 3'b000} +: 8] = in_char;
    fill_cnt = {1'b0, idx} + {2'b00, store_byte};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= 2'd0;
      lanes <= 32'h0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      lanes <= lanes_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    lanes_nxt = lanes;
    case (state)
      FILL: begin
        if (store_byte && idx == 2'd3) begin
          idx_nxt   = 2'd0;
          lanes_nxt = 32'h0;
        end else if (flush_req && fill_cnt != 3'd0) begin
          if (!fifo_full) begin
            idx_nxt   = 2'd0;
            lanes_nxt = 32'h0;
          end else begin
            idx_nxt   = fill_cnt[1:0];
            lanes_nxt = merged;
            state_nxt = FLUSH_WAIT;
          end
        end else begin
          idx_nxt   = fill_cnt[1:0];
          lanes_nxt = merged;
        end
      end
      FLUSH_WAIT: begin
        if (!fifo_full) begin
          idx_nxt   = 2'd0;
          lanes_nxt = 32'h0;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    push_vld = 1'b0;
    push_dat = '0;
    case (state)
      FILL: begin
        if (store_byte && idx == 2'd3) begin
          push_vld       = 1'b1;
          push_dat.word  = merged;
          push_dat.count = 3'd4;
          push_dat.last  = flush_req;
        end else if (flush_req && fill_cnt != 3'd0 && !fifo_full) begin
          push_vld       = 1'b1;
          push_dat.word  = merged;
          push_dat.count = fill_cnt;
          push_dat.last  = 1'b1;
        end
      end
      FLUSH_WAIT: begin
        if (!fifo_full) begin
          push_vld       = 1'b1;
          push_dat.word  = lanes;
          push_dat.count = {1'b0, idx};
          push_dat.last  = 1'b1;
        end
      end
      default: push_vld = 1'b0;
    endcase
    if (rst) push_vld = 1'b0;
  end

  cwp_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (out_ready),
    .pop_vld  (out_valid),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .level    (fifo_level)
  );

  assign out_word  = pop_dat.word;
  assign out_count = pop_dat.count;
  assign out_last  = pop_dat.last;
endmodule

// File: tb/tb_char_word_packer.sv
// Bench for char_word_packer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of bytes, partial words and the word FIFO.
module tb_char_word_packer;
  localparam int DEPTH = 4;
  localparam int LVW   = $clog2(DEPTH) + 1;
`ifdef PACKER_NUL_TERM_EN
  localparam bit NUL_EN = 1'b1;
`else
  localparam bit NUL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     in_char = 8'h00;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_flush = 1'b0;
  logic [31:0]    out_word;
  logic [2:0]     out_count;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [LVW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int pops_seen = 0;
  bit mon_en = 1'b0;

  logic [7:0]  part_q[$];
  logic [35:0] fifo_q[$];
  bit          pend = 1'b0;

  char_word_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_char    (in_char),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flush   (in_flush),
    .out_word   (out_word),
    .out_count  (out_count),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] mk_word(input bit last);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < part_q.size(); k++) w[8*k +: 8] = part_q[k];
    return {last, 3'(part_q.size()), w};
  endfunction

  function automatic bit m_ready();
    return !pend && (part_q.size() != 3 || fifo_q.size() < DEPTH);
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    bit full, pop, push, acc, nul, store, fl;
    logic [35:0] nw;
    if (rst) begin
      part_q.delete();
      fifo_q.delete();
      pend = 1'b0;
      return;
    end
    full = (fifo_q.size() == DEPTH);
    pop  = (fifo_q.size() != 0) && out_ready;
    push = 1'b0;
    nw   = '0;
    if (pend) begin
      if (!full) begin
        nw = mk_word(1'b1); push = 1'b1; part_q.delete(); pend = 1'b0;
      end
    end else begin
      acc   = in_valid && m_ready();
      nul   = NUL_EN && (in_char == 8'h00);
      store = acc && !nul;
      fl    = in_flush || (acc && nul);
      if (store) part_q.push_back(in_char);
      if (part_q.size() == 4) begin
        nw = mk_word(fl); push = 1'b1; part_q.delete();
      end else if (fl && part_q.size() > 0) begin
        if (!full) begin
          nw = mk_word(1'b1); push = 1'b1; part_q.delete();
        end else begin
          pend = 1'b1;
        end
      end
    end
    if (pop) void'(fifo_q.pop_front());
    if (push) fifo_q.push_back(nw);
  endtask

  task automatic step(input bit v, input logic [7:0] ch, input bit fl, input bit ordy, input bit r);
    @(negedge clk);
    in_valid = v; in_char = ch; in_flush = fl; out_ready = ordy; rst = r;
    #3;
    model_update();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [35:0] e;
    bit          exp_rdy;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        e = (fifo_q.size() != 0) ? fifo_q[0] : 36'h0;
        exp_rdy = !rst && m_ready();
        checks += 5;
        if (in_ready !== exp_rdy) begin
          errors++; $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
        end
        if (out_valid !== (fifo_q.size() != 0)) begin
          errors++; $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, fifo_q.size() != 0);
        end
        if (out_word !== e[31:0]) begin
          errors++; $display("FAIL out_word t=%0t got %h want %h", $time, out_word, e[31:0]);
        end
        if (out_count !== e[34:32] || out_last !== e[35]) begin
          errors++; $display("FAIL count_last t=%0t got %0d/%b want %0d/%b", $time, out_count, out_last, e[34:32], e[35]);
        end
        if (fifo_level !== LVW'(fifo_q.size())) begin
          errors++; $display("FAIL fifo_level t=%0t got %0d want %0d", $time, fifo_level, fifo_q.size());
        end
        if (out_valid === 1'b1 && out_ready === 1'b1 && !rst) pops_seen++;
      end
    end
  end

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_word !== 32'h0 || out_count !== 3'd0 ||
        out_last !== 1'b0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b word=%h cnt=%0d last=%b lvl=%0d want all zero",
               in_ready, out_valid, out_word, out_count, out_last, fifo_level);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_full_word();
    logic [7:0] b [4] = '{8'h48, 8'h41, 8'h4C, 8'h54};
    for (int i = 0; i < 4; i++) step(1'b1, b[i], 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h544C4148 || out_count !== 3'd4 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL full_word got vld=%b %h cnt=%0d last=%b want 1 544c4148 4 0", out_valid, out_word, out_count, out_last);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h00004241 || out_count !== 3'd2 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL flush_partial got vld=%b %h cnt=%0d last=%b want 1 00004241 2 1", out_valid, out_word, out_count, out_last);
    end
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== '0) begin
      errors++; $display("FAIL flush_empty got vld=%b lvl=%0d want 0 0", out_valid, fifo_level);
    end
  endtask

  task automatic test_flush_with_byte();
    step(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_word !== 32'h5A434241 || out_count !== 3'd4 || out_last !== 1'b1) begin
      errors++; $display("FAIL flush_byte_idx3 got %h cnt=%0d last=%b want 5a434241 4 1", out_word, out_count, out_last);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int p0;
    for (int i = 0; i < 19; i++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== LVW'(4) || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full got lvl=%0d rdy=%b want 4 0", fifo_level, in_ready);
    end
    p0 = pops_seen;
    step(1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12 && out_valid === 1'b1; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pops_seen - p0 != 5 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got %0d words vld=%b want 5 0", pops_seen - p0, out_valid);
    end
  endtask

  task automatic test_flush_wait();
    for (int i = 0; i < 18; i++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || fifo_level !== LVW'(4)) begin
      errors++; $display("FAIL flush_wait got rdy=%b lvl=%0d want 0 4", in_ready, fifo_level);
    end
    for (int i = 0; i < 12 && (out_valid === 1'b1 || in_ready !== 1'b1); i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_wait_drain got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_nul();
`ifdef PACKER_NUL_TERM_EN
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_word !== 32'h00000041 || out_count !== 3'd1 || out_last !== 1'b1) begin
      errors++; $display("FAIL nul_term got %h cnt=%0d last=%b want 00000041 1 1", out_word, out_count, out_last);
    end
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL nul_idx0 got vld=%b want 0", out_valid);
    end
`else
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_word !== 32'h43420041 || out_count !== 3'd4 || out_last !== 1'b0) begin
      errors++; $display("FAIL nul_packed got %h cnt=%0d last=%b want 43420041 4 0", out_word, out_count, out_last);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [4] = '{8'h57, 8'h58, 8'h59, 8'h5A};
    step(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== '0) begin
      errors++; $display("FAIL reset_mid_clear got vld=%b lvl=%0d want 0 0", out_valid, fifo_level);
    end
    for (int i = 0; i < 4; i++) step(1'b1, b[i], 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== LVW'(1) || out_word !== 32'h5A595857 || out_count !== 3'd4) begin
      errors++; $display("FAIL reset_mid_word got lvl=%0d %h cnt=%0d want 1 5a595857 4", fifo_level, out_word, out_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit ordy_bias;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ordy_bias = ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
           $urandom_range(0, 11) == 0,
           ordy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 699) == 0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && (out_valid === 1'b1 || in_ready !== 1'b1); i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== '0) begin
      errors++; $display("FAIL random_drain got vld=%b lvl=%0d want 0 0", out_valid, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_flush_with_byte();
    test_backpressure();
    test_flush_wait();
    test_nul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
